// File: rtl/dbus_arbiter.sv
// Two-master round-robin arbiter for the shared CPU data bus (dmem_* channels).
// Supports locked ownership for atomic sequences, with a burst limit that bounds starvation.
module dbus_arbiter #(
  parameter int AW        = 32,
  parameter int MAX_BURST = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          m0_req,
  input  logic          m0_we,
  input  logic          m0_lock,
  input  logic [AW-1:0] m0_addr,
  input  logic [31:0]   m0_wdata,
  input  logic [3:0]    m0_wstrb,
  output logic          m0_gnt,
  output logic          m0_rvalid,
  output logic [31:0]   m0_rdata,
  input  logic          m1_req,
  input  logic          m1_we,
  input  logic          m1_lock,
  input  logic [AW-1:0] m1_addr,
  input  logic [31:0]   m1_wdata,
  input  logic [3:0]    m1_wstrb,
  output logic          m1_gnt,
  output logic          m1_rvalid,
  output logic [31:0]   m1_rdata,
  output logic          dmem_wr,
  output logic [AW-1:0] dmem_waddr,
  output logic [31:0]   dmem_wdata,
  output logic [3:0]    dmem_wstrb,
  output logic          dmem_rd,
  output logic [AW-1:0] dmem_raddr,
  input  logic [31:0]   dmem_rdata,
  output logic          cpu_stall
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] OWN0 = 2'd1;
  localparam logic [1:0] OWN1 = 2'd2;
  localparam logic [7:0] BURST_LAST = 8'(MAX_BURST - 1);

  logic [1:0]    state, state_nxt;
  logic          last;
  logic [7:0]    burst_cnt, burst_nxt;
  logic          rd_pend, rd_id;
  logic          g0, g1, gnt_any, sel, sel_we, sel_lock, other_req, force_idle;
  logic [AW-1:0] sel_addr;

  // In IDLE a tie goes to the master that was not granted last.
  always_comb begin
    g0 = 1'b0;
    g1 = 1'b0;
    if (!rst) begin
      case (state)
        IDLE: begin
          if (m0_req && m1_req) begin
            g0 = last;
            g1 = ~last;
          end else begin
            g0 = m0_req;
            g1 = m1_req;
          end
        end
        OWN0:    g0 = m0_req;
        OWN1:    g1 = m1_req;
        default: ;
      endcase
    end
  end

  assign gnt_any    = g0 | g1;
  assign sel        = g1;
  assign sel_we     = sel ? m1_we   : m0_we;
  assign sel_lock   = sel ? m1_lock : m0_lock;
  assign sel_addr   = sel ? m1_addr : m0_addr;
  assign other_req  = sel ? m0_req  : m1_req;
  assign force_idle = gnt_any & other_req & (burst_cnt == BURST_LAST);

  always_comb begin
    state_nxt = state;
    burst_nxt = burst_cnt;
    if (gnt_any) begin
      state_nxt = (sel_lock && !force_idle) ? (sel ? OWN1 : OWN0) : IDLE;
      if (force_idle || !other_req)
        burst_nxt = 8'd0;
      else if (sel == last)
        burst_nxt = 8'(burst_cnt + 8'd1);
      else
        burst_nxt = 8'd1;
    end else if ((state == OWN0 && !m0_req && !m0_lock) ||
                 (state == OWN1 && !m1_req && !m1_lock)) begin
      state_nxt = IDLE;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      last      <= 1'b1;
      burst_cnt <= 8'd0;
      rd_pend   <= 1'b0;
      rd_id     <= 1'b0;
    end else begin
      state   <= state_nxt;
      rd_pend <= gnt_any & ~sel_we;
      rd_id   <= sel;
      if (gnt_any) begin
        last      <= sel;
        burst_cnt <= burst_nxt;
      end
    end
  end

  assign m0_gnt     = g0;
  assign m1_gnt     = g1;
  assign cpu_stall  = ~rst & m0_req & ~g0;

  assign dmem_wr    = gnt_any & sel_we;
  assign dmem_rd    = gnt_any & ~sel_we;
  assign dmem_waddr = dmem_wr ? sel_addr : '0;
  assign dmem_wdata = dmem_wr ? (sel ? m1_wdata : m0_wdata) : 32'd0;
  assign dmem_wstrb = dmem_wr ? (sel ? m1_wstrb : m0_wstrb) : 4'd0;
  assign dmem_raddr = dmem_rd ? sel_addr : '0;

  // Read data follows the grant by one cycle, matching the interconnect's registered mux.
  assign m0_rvalid  = ~rst & rd_pend & ~rd_id;
  assign m1_rvalid  = ~rst & rd_pend & rd_id;
  assign m0_rdata   = m0_rvalid ? dmem_rdata : 32'd0;
  assign m1_rdata   = m1_rvalid ? dmem_rdata : 32'd0;

endmodule

// File: tb/tb_dbus_arbiter.sv
// Directed bench for dbus_arbiter: reset, round-robin, lock, burst limit, write path, reset mid-read.
module tb_dbus_arbiter;
  logic        clk = 1'b0;
  logic        rst;
  logic        m0_req, m0_we, m0_lock, m1_req, m1_we, m1_lock;
  logic [31:0] m0_addr, m0_wdata, m1_addr, m1_wdata;
  logic [3:0]  m0_wstrb, m1_wstrb;
  logic        m0_gnt, m0_rvalid, m1_gnt, m1_rvalid;
  logic [31:0] m0_rdata, m1_rdata;
  logic        dmem_wr, dmem_rd, cpu_stall;
  logic [31:0] dmem_waddr, dmem_wdata, dmem_raddr, dmem_rdata;
  logic [3:0]  dmem_wstrb;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  dbus_arbiter #(.AW(32), .MAX_BURST(4)) dut (
    .clk(clk), .rst(rst),
    .m0_req(m0_req), .m0_we(m0_we), .m0_lock(m0_lock), .m0_addr(m0_addr),
    .m0_wdata(m0_wdata), .m0_wstrb(m0_wstrb), .m0_gnt(m0_gnt),
    .m0_rvalid(m0_rvalid), .m0_rdata(m0_rdata),
    .m1_req(m1_req), .m1_we(m1_we), .m1_lock(m1_lock), .m1_addr(m1_addr),
    .m1_wdata(m1_wdata), .m1_wstrb(m1_wstrb), .m1_gnt(m1_gnt),
    .m1_rvalid(m1_rvalid), .m1_rdata(m1_rdata),
    .dmem_wr(dmem_wr), .dmem_waddr(dmem_waddr), .dmem_wdata(dmem_wdata),
    .dmem_wstrb(dmem_wstrb), .dmem_rd(dmem_rd), .dmem_raddr(dmem_raddr),
    .dmem_rdata(dmem_rdata), .cpu_stall(cpu_stall)
  );

  task automatic idle_inputs();
    m0_req = 0; m0_we = 0; m0_lock = 0; m0_addr = 0; m0_wdata = 0; m0_wstrb = 0;
    m1_req = 0; m1_we = 0; m1_lock = 0; m1_addr = 0; m1_wdata = 0; m1_wstrb = 0;
    dmem_rdata = 32'h0;
  endtask

  // Tasks start and end at posedge+1.
  task automatic do_reset();
    idle_inputs();
    rst = 1;
    @(posedge clk); #1;
    rst = 0;
  endtask

  task automatic next_cycle();
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    rst = 1;
    m0_req = 1; m1_req = 1; m0_addr = 32'h10; m1_addr = 32'h20;
    m0_we = 1; m0_wdata = 32'h1234; m0_wstrb = 4'hF;
    dmem_rdata = 32'hFFFF_FFFF;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      checks++;
      if ({m0_gnt, m1_gnt, m0_rvalid, m1_rvalid, dmem_wr, dmem_rd, cpu_stall} !== 7'b0 ||
          m0_rdata !== 0 || m1_rdata !== 0 || dmem_waddr !== 0 || dmem_wdata !== 0 ||
          dmem_wstrb !== 0 || dmem_raddr !== 0) begin
        errors++;
        $display("FAIL reset_outputs cycle %0d: gnt=%b%b rv=%b%b wr=%b rd=%b stall=%b wdata=%h expected all 0",
                 i, m0_gnt, m1_gnt, m0_rvalid, m1_rvalid, dmem_wr, dmem_rd, cpu_stall, dmem_wdata);
      end
      next_cycle();
    end
    rst = 0;
    @(negedge clk);
    checks++;
    if ({m0_gnt, m1_gnt, cpu_stall} !== 3'b100) begin
      errors++;
      $display("FAIL reset_first_grant: m0_gnt=%b m1_gnt=%b cpu_stall=%b expected 1 0 0",
               m0_gnt, m1_gnt, cpu_stall);
    end
    next_cycle();
  endtask

  task automatic test_round_robin();
    logic exp_g1, prev_g1;
    logic [31:0] exp_rd0, exp_rd1;
    do_reset();
    m0_req = 1; m0_addr = 32'h0100_0000;
    m1_req = 1; m1_addr = 32'h0100_0004;
    prev_g1 = 0;
    for (int i = 0; i < 7; i++) begin
      if (i == 6) begin m0_req = 0; m1_req = 0; end
      dmem_rdata = 32'hD000_0000 + i;
      @(negedge clk);
      exp_g1 = i[0];
      if (i < 6) begin
        checks++;
        if ({m0_gnt, m1_gnt} !== {~exp_g1, exp_g1} || dmem_rd !== 1'b1 || dmem_wr !== 1'b0 ||
            dmem_raddr !== (exp_g1 ? 32'h0100_0004 : 32'h0100_0000)) begin
          errors++;
          $display("FAIL rr_grant cycle %0d: gnt=%b%b rd=%b raddr=%h expected gnt=%b%b raddr=%h",
                   i, m0_gnt, m1_gnt, dmem_rd, dmem_raddr, ~exp_g1, exp_g1,
                   exp_g1 ? 32'h0100_0004 : 32'h0100_0000);
        end
      end
      exp_rd0 = (i > 0 && !prev_g1) ? 32'hD000_0000 + i : 32'h0;
      exp_rd1 = (i > 0 &&  prev_g1) ? 32'hD000_0000 + i : 32'h0;
      checks++;
      if (m0_rvalid !== (i > 0 && !prev_g1) || m1_rvalid !== (i > 0 && prev_g1) ||
          m0_rdata !== exp_rd0 || m1_rdata !== exp_rd1) begin
        errors++;
        $display("FAIL rr_return cycle %0d: rv=%b%b rdata0=%h rdata1=%h expected rv=%b%b rdata0=%h rdata1=%h",
                 i, m0_rvalid, m1_rvalid, m0_rdata, m1_rdata,
                 (i > 0 && !prev_g1), (i > 0 && prev_g1), exp_rd0, exp_rd1);
      end
      prev_g1 = exp_g1;
      next_cycle();
    end
  endtask

  task automatic test_lock();
    do_reset();
    m0_req = 1; m0_we = 1; m0_addr = 32'h40; m0_wdata = 32'h1; m0_wstrb = 4'hF;
    next_cycle();
    m0_we = 0;
    m1_req = 1; m1_we = 1; m1_wstrb = 4'hF;
    for (int k = 0; k < 3; k++) begin
      m1_lock = (k < 2);
      m1_addr = 32'h0300_0000;
      m1_wdata = 32'hC0DE_0000 + k;
      @(negedge clk);
      checks++;
      if ({m0_gnt, m1_gnt, cpu_stall, dmem_wr} !== 4'b0111 || dmem_waddr !== 32'h0300_0000 ||
          dmem_wdata !== 32'hC0DE_0000 + k) begin
        errors++;
        $display("FAIL lock_hold xfer %0d: gnt=%b%b stall=%b wr=%b waddr=%h wdata=%h expected gnt=01 stall=1 wr=1 waddr=03000000 wdata=%h",
                 k, m0_gnt, m1_gnt, cpu_stall, dmem_wr, dmem_waddr, dmem_wdata, 32'hC0DE_0000 + k);
      end
      next_cycle();
    end
    m1_req = 0; m1_lock = 0;
    @(negedge clk);
    checks++;
    if ({m0_gnt, m1_gnt, cpu_stall} !== 3'b100) begin
      errors++;
      $display("FAIL lock_release: gnt=%b%b stall=%b expected gnt=10 stall=0", m0_gnt, m1_gnt, cpu_stall);
    end
    next_cycle();
  endtask

  task automatic test_burst_limit();
    logic [5:0] exp_g1;
    exp_g1 = 6'b101111;  // bit i = m1 granted in cycle i
    do_reset();
    m0_req = 1; m0_we = 1; m0_addr = 32'h44;
    next_cycle();
    m0_we = 0;
    m1_req = 1; m1_we = 1; m1_lock = 1; m1_addr = 32'h0300_0010; m1_wstrb = 4'hF;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      checks++;
      if ({m0_gnt, m1_gnt} !== {~exp_g1[i], exp_g1[i]}) begin
        errors++;
        $display("FAIL burst_grant cycle %0d: gnt=%b%b expected gnt=%b%b",
                 i, m0_gnt, m1_gnt, ~exp_g1[i], exp_g1[i]);
      end
      next_cycle();
    end
  endtask

  task automatic test_write_passthrough();
    do_reset();
    m0_req = 1; m0_we = 1; m0_addr = 32'h0200_0004; m0_wdata = 32'hA5; m0_wstrb = 4'b0001;
    @(negedge clk);
    checks++;
    if ({m0_gnt, dmem_wr, dmem_rd} !== 3'b110 || dmem_waddr !== 32'h0200_0004 ||
        dmem_wdata !== 32'hA5 || dmem_wstrb !== 4'b0001 || dmem_raddr !== 32'h0) begin
      errors++;
      $display("FAIL write_pass: gnt=%b wr=%b rd=%b waddr=%h wdata=%h wstrb=%b expected 1 1 0 02000004 000000a5 0001",
               m0_gnt, dmem_wr, dmem_rd, dmem_waddr, dmem_wdata, dmem_wstrb);
    end
    next_cycle();
    m0_req = 0;
    @(negedge clk);
    checks++;
    if ({m0_gnt, m1_gnt, dmem_wr, dmem_rd, m0_rvalid} !== 5'b0 || dmem_waddr !== 0 ||
        dmem_wdata !== 0 || dmem_wstrb !== 0 || dmem_raddr !== 0) begin
      errors++;
      $display("FAIL no_grant_bus: gnt=%b%b wr=%b rd=%b rv=%b waddr=%h wdata=%h expected all 0",
               m0_gnt, m1_gnt, dmem_wr, dmem_rd, m0_rvalid, dmem_waddr, dmem_wdata);
    end
    next_cycle();
  endtask

  task automatic test_reset_mid_read();
    do_reset();
    m0_req = 1; m0_addr = 32'h0100_0008; dmem_rdata = 32'hBEEF_0001;
    @(negedge clk);
    checks++;
    if ({m0_gnt, dmem_rd} !== 2'b11) begin
      errors++;
      $display("FAIL midread_grant: gnt=%b rd=%b expected 1 1", m0_gnt, dmem_rd);
    end
    rst = 1; m0_req = 0;
    next_cycle();
    rst = 0;
    @(negedge clk);
    checks++;
    if (m0_rvalid !== 1'b0 || m0_rdata !== 32'h0) begin
      errors++;
      $display("FAIL midread_dropped: m0_rvalid=%b m0_rdata=%h expected 0 0", m0_rvalid, m0_rdata);
    end
    next_cycle();
    m0_req = 1; m1_req = 1; m1_addr = 32'h0100_000C;
    @(negedge clk);
    checks++;
    if ({m0_gnt, m1_gnt} !== 2'b10) begin
      errors++;
      $display("FAIL midread_last: gnt=%b%b expected 10", m0_gnt, m1_gnt);
    end
    next_cycle();
    idle_inputs();
  endtask

  initial begin
    idle_inputs();
    rst = 1;
    #1;
    test_reset();
    test_round_robin();
    test_lock();
    test_burst_limit();
    test_write_passthrough();
    test_reset_mid_read();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/dbus_arbiter.md
# dbus_arbiter

Two-master arbiter that shares the single CPU data bus (`dmem_*` read/write channels feeding the rbus/wbus interconnect) between the RISC-V core (master 0) and a second bus master (master 1, e.g. a UART program loader or DMA engine). It grants at most one transfer per cycle, routes the selected master's request onto the bus, and returns read data to the issuing master one cycle later, matching the interconnect's registered read mux. Arbitration is round-robin, with an optional lock for atomic sequences and a burst limit that prevents starvation.

## Interface
- `AW`, 32: address width on master and bus side
- `MAX_BURST`, 8: maximum consecutive grants to one owner while the other master requests; range 1..255
- `clk` in 1: system clock
- `rst` in 1: synchronous reset, active-high
- `mN_req` in 1 (N=0,1): transfer request, held until granted
- `mN_we` in 1: 1 = write, 0 = read
- `mN_lock` in 1: keep ownership after this transfer
- `mN_addr` in AW: byte address
- `mN_wdata` in 32: write data
- `mN_wstrb` in 4: byte strobes, writes only
- `mN_gnt` out 1: request accepted this cycle
- `mN_rvalid` out 1: read data valid for this master
- `mN_rdata` out 32: read data, 0 when `mN_rvalid`=0
- `dmem_wr` out 1, `dmem_waddr` out AW, `dmem_wdata` out 32, `dmem_wstrb` out 4: bus write channel
- `dmem_rd` out 1, `dmem_raddr` out AW: bus read channel
- `dmem_rdata` in 32: bus read data, valid the cycle after `dmem_rd`
- `cpu_stall` out 1: `m0_req & ~m0_gnt`, drives the core's stall input

## Operation
- FSM states: IDLE (no owner), OWN0, OWN1. Registers: `last` (last granted master), `burst_cnt` (8 bit), `rd_pend`, `rd_id`.
- IDLE: a single requester is granted. If both request, the master ≠ `last` is granted. After reset `last`=1, so master 0 wins the first tie.
- Granted transfer with `mN_lock`=1: go to OWNN. With `lock`=0: return to IDLE, or stay in IDLE.
- OWNN: only master N may be granted; the other master's request waits. Leave to IDLE when a granted transfer of N has `lock`=0, or when N drops `req` and `lock`.
- Burst limit: `burst_cnt` counts consecutive grants to the same master while the other master's `req`=1, and resets when ownership changes or the other master is idle. When `burst_cnt`=MAX_BURST-1 and a grant occurs, the FSM is forced to IDLE and `last` is set so the other master wins next cycle. This applies even while locked.
- Per cycle, at most one of `dmem_wr`/`dmem_rd` is asserted. Both carry the granted master's address/data/strobes. With no grant, all `dmem_*` outputs are 0.
- Read return: a granted read sets `rd_pend`=1 and `rd_id`=N at the next edge. In the following cycle, `mN_rvalid`=1 and `mN_rdata`=`dmem_rdata` for N=`rd_id`. The other master sees `rvalid`=0 and `rdata`=0.
- A new grant is allowed in the same cycle a read returns (back-to-back reads, 1 per cycle).
- Writes have no response; a grant means the write is complete.
- Addresses are passed through unmodified. Slave decode stays in the interconnect.

## Timing
- `gnt`, `cpu_stall` and `dmem_*` are combinational from `req`/`we`/`lock` and the registered state, with no added request latency. Read latency is grant + 1 cycle.
- Reset (synchronous, `rst`=1 at a clk edge): state=IDLE, `last`=1, `burst_cnt`=0, `rd_pend`=0.
- While `rst`=1, all outputs are held 0: `gnt`, `rvalid`, `rdata`, `dmem_*` and `cpu_stall`.
- Reset during a pending read drops the return: no `rvalid` the cycle after reset releases.
- Simultaneous requests in IDLE are resolved by `last`. The losing master must hold `req`, `addr` and `data` stable until granted.
- `lock` is sampled only on granted cycles. `MAX_BURST`=1 gives strict alternation under contention.

## Test plan
- Reset: hold `rst`=1 for 2 cycles with both `req`=1 → all outputs 0. First cycle after release: `m0_gnt`=1, `m1_gnt`=0, `cpu_stall`=0.
- Round-robin: both masters issue continuous reads, m0 at 0x0100_0000, m1 at 0x0100_0004 → grants alternate 0,1,0,1. `dmem_raddr` alternates accordingly. `mN_rvalid` arrives exactly 1 cycle after each `mN_gnt` and carries the `dmem_rdata` value of that cycle.
- Lock: m1 write to 0x0300_0000 with `lock`=1 for 3 transfers while m0 requests → `m1_gnt` for 3 consecutive cycles and `cpu_stall`=1 during them. m1's last transfer has `lock`=0. m0 is granted the next cycle.
- Burst limit: MAX_BURST=4; m1 keeps `lock`=1 and `req`=1 while m0 requests → m1 gets 4 grants, m0 gets 1 grant, then m1 resumes.
- Write pass-through: m0 write to 0x0200_0004, wdata 0xA5, wstrb 4'b0001 → same cycle `dmem_wr`=1 with identical waddr/wdata/wstrb, and `dmem_rd`=0.
- Reset mid-read: m0 read is granted, `rst`=1 on the next edge → `m0_rvalid` stays 0, and state returns to IDLE with `last`=1.
